// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer.
//
// Accepts mult/multu/div/divu/mthi/mtlo from the E stage. Multiply and
// divide occupy the unit for a fixed number of cycles before committing to
// the HI/LO registers owned here. mthi/mtlo write HI/LO directly. An
// E-stage cancel keeps a flushed instruction from starting or writing.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   E_MDU_op     in   [3:0] 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                     5 mthi, 6 mtlo; 7-15 behave as none
//   E_MDU_A      in   [31:0] forwarded rs
//   E_MDU_B      in   [31:0] forwarded rt
//   E_req_cancel in   E instruction is being flushed
//   E_MDU_start  out  combinational: operation accepted this cycle
//   E_MDU_busy   out  registered: operation in progress
//   E_HI, E_LO   out  [31:0] current HI/LO registers
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDU_op,
  input  logic [31:0] E_MDU_A,
  input  logic [31:0] E_MDU_B,
  input  logic        E_req_cancel,
  output logic        E_MDU_start,
  output logic        E_MDU_busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        start_s;
  logic [63:0] smul_s;
  logic [63:0] umul_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] sdiv_den_s;
  logic [31:0] udiv_den_s;
  logic [31:0] uq_mag_s;
  logic [31:0] ur_mag_s;
  logic [31:0] sq_s;
  logic [31:0] sr_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;

  // Accept a multiply/divide only when idle and the E instruction survives.
  assign start_s = (E_MDU_op >= OP_MULT) && (E_MDU_op <= OP_DIVU) &&
                   !E_req_cancel && (state_q == IDLE);

  // Arithmetic on the latched operands; only the commit is delayed.
  assign smul_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign umul_s = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide works on magnitudes so 0x80000000 / -1 needs no special
  // case: the magnitude quotient 0x80000000 negates back to itself.
  assign abs_a_s    = a_q[31] ? (32'd0 - a_q) : a_q;
  assign abs_b_s    = b_q[31] ? (32'd0 - b_q) : b_q;
  // Zero divisors are substituted with 1 only to keep the datapath defined;
  // the commit is suppressed in that case.
  assign sdiv_den_s = (abs_b_s == 32'd0) ? 32'd1 : abs_b_s;
  assign udiv_den_s = (b_q == 32'd0) ? 32'd1 : b_q;
  assign uq_mag_s   = abs_a_s / sdiv_den_s;
  assign ur_mag_s   = abs_a_s % sdiv_den_s;
  assign sq_s       = (a_q[31] ^ b_q[31]) ? (32'd0 - uq_mag_s) : uq_mag_s;
  assign sr_s       = a_q[31] ? (32'd0 - ur_mag_s) : ur_mag_s;
  assign uq_s       = a_q / udiv_den_s;
  assign ur_s       = a_q % udiv_den_s;

  // Next-state, latching and HI/LO write selection.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          op_d    = E_MDU_op;
          a_d     = E_MDU_A;
          b_d     = E_MDU_B;
          cnt_d   = ((E_MDU_op == OP_MULT) || (E_MDU_op == OP_MULTU)) ?
                    32'(MULT_CYCLES) : 32'(DIV_CYCLES);
          state_d = RUN;
          busy_d  = 1'b1;
        end else if (!E_req_cancel && (E_MDU_op == OP_MTHI)) begin
          hi_d = E_MDU_A;
        end else if (!E_req_cancel && (E_MDU_op == OP_MTLO)) begin
          lo_d = E_MDU_A;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // New E-stage ops are ignored here; the running op always finishes.
        cnt_d = cnt_q - 32'd1;
        if (cnt_q == 32'd1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          case (op_q)
            OP_MULT: begin
              hi_d = smul_s[63:32];
              lo_d = smul_s[31:0];
            end
            OP_MULTU: begin
              hi_d = umul_s[63:32];
              lo_d = umul_s[31:0];
            end
            OP_DIV: begin
              if (b_q != 32'd0) begin
                hi_d = sr_s;
                lo_d = sq_s;
              end else begin
                hi_d = hi_q;
              end
            end
            OP_DIVU: begin
              if (b_q != 32'd0) begin
                hi_d = ur_s;
                lo_d = uq_s;
              end else begin
                hi_d = hi_q;
              end
            end
            default: begin
              hi_d = hi_q;
            end
          endcase
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter, latched operation and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= 32'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign E_MDU_start = start_s;
  assign E_MDU_busy  = busy_q;
  assign E_HI        = hi_q;
  assign E_LO        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl with default
// latencies (mult 5, div 10). Inputs change 1 ns after a rising edge;
// registered outputs are sampled there too, combinational start 1 ns later.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  E_MDU_op;
  logic [31:0] E_MDU_A;
  logic [31:0] E_MDU_B;
  logic        E_req_cancel;
  logic        E_MDU_start;
  logic        E_MDU_busy;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  int n_cmp;
  int n_bad;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .E_MDU_op     (E_MDU_op),
    .E_MDU_A      (E_MDU_A),
    .E_MDU_B      (E_MDU_B),
    .E_req_cancel (E_req_cancel),
    .E_MDU_start  (E_MDU_start),
    .E_MDU_busy   (E_MDU_busy),
    .E_HI         (E_HI),
    .E_LO         (E_LO)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div now, then follow it through its busy window and commit.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n_busy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    E_MDU_op = op;
    E_MDU_A  = a;
    E_MDU_B  = b;
    #1;
    check({tag, " start"}, {31'd0, E_MDU_start}, 32'd1);
    step();
    E_MDU_op = 4'd0;
    for (int i = 0; i < n_busy; i++) begin
      check({tag, " busy"}, {31'd0, E_MDU_busy}, 32'd1);
      check({tag, " start_in_run"}, {31'd0, E_MDU_start}, 32'd0);
      step();
    end
    check({tag, " busy_done"}, {31'd0, E_MDU_busy}, 32'd0);
    check({tag, " hi"}, E_HI, exp_hi);
    check({tag, " lo"}, E_LO, exp_lo);
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    reset        = 1'b1;
    E_MDU_op     = 4'd0;
    E_MDU_A      = 32'd0;
    E_MDU_B      = 32'd0;
    E_req_cancel = 1'b0;
    step();
    step();
    check("rst busy", {31'd0, E_MDU_busy}, 32'd0);
    check("rst hi", E_HI, 32'd0);
    check("rst lo", E_LO, 32'd0);
    reset = 1'b0;
    step();

    // Signed/unsigned multiply, then divide issued the cycle results appear.
    run_op("mult",  4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    // Preload HI/LO, divide by zero leaves them alone.
    E_MDU_op = 4'd5;
    E_MDU_A  = 32'h11;
    #1;
    check("mthi start", {31'd0, E_MDU_start}, 32'd0);
    step();
    check("mthi busy", {31'd0, E_MDU_busy}, 32'd0);
    check("mthi hi", E_HI, 32'h11);
    E_MDU_op = 4'd6;
    E_MDU_A  = 32'h22;
    step();
    check("mtlo lo", E_LO, 32'h22);
    check("mtlo hi", E_HI, 32'h11);
    run_op("divu0", 4'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22);
    run_op("div0",  4'd3, 32'd7, 32'd0, 10, 32'h11, 32'h22);
    run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // Cancelled mult never starts.
    E_MDU_op     = 4'd1;
    E_MDU_A      = 32'd9;
    E_MDU_B      = 32'd9;
    E_req_cancel = 1'b1;
    #1;
    check("cancel start", {31'd0, E_MDU_start}, 32'd0);
    step();
    E_MDU_op = 4'd0;
    for (int i = 0; i < 6; i++) begin
      check("cancel busy", {31'd0, E_MDU_busy}, 32'd0);
      step();
    end
    check("cancel hi", E_HI, 32'd0);
    check("cancel lo", E_LO, 32'h8000_0000);
    // Cancelled mthi, then the same mthi allowed.
    E_MDU_op = 4'd5;
    E_MDU_A  = 32'h5A;
    step();
    check("cancel mthi hi", E_HI, 32'd0);
    E_req_cancel = 1'b0;
    step();
    check("mthi 5a hi", E_HI, 32'h5A);
    E_MDU_op = 4'd0;
    step();

    // Reset in the fourth busy cycle of a divide.
    E_MDU_op = 4'd3;
    E_MDU_A  = 32'd100;
    E_MDU_B  = 32'd7;
    #1;
    check("rdiv start", {31'd0, E_MDU_start}, 32'd1);
    step();
    E_MDU_op = 4'd0;
    step();
    step();
    step();
    check("rdiv busy4", {31'd0, E_MDU_busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("rdiv async busy", {31'd0, E_MDU_busy}, 32'd0);
    check("rdiv async hi", E_HI, 32'd0);
    check("rdiv async lo", E_LO, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
    end
    check("rdiv late busy", {31'd0, E_MDU_busy}, 32'd0);
    check("rdiv late hi", E_HI, 32'd0);
    check("rdiv late lo", E_LO, 32'd0);

    // Overlapping ops during RUN are ignored; the running multu still commits.
    E_MDU_op = 4'd2;
    E_MDU_A  = 32'h0001_0000;
    E_MDU_B  = 32'h0003_0000;
    #1;
    check("ovl start", {31'd0, E_MDU_start}, 32'd1);
    step();
    E_MDU_op = 4'd5;
    E_MDU_A  = 32'hABCD;
    #1;
    check("ovl mthi start", {31'd0, E_MDU_start}, 32'd0);
    step();
    E_MDU_op = 4'd1;
    E_MDU_A  = 32'd2;
    E_MDU_B  = 32'd2;
    #1;
    check("ovl mult start", {31'd0, E_MDU_start}, 32'd0);
    check("ovl hi kept", E_HI, 32'd0);
    step();
    E_MDU_op = 4'd0;
    for (int i = 0; i < 3; i++) begin
      check("ovl busy", {31'd0, E_MDU_busy}, 32'd1);
      step();
    end
    check("ovl done busy", {31'd0, E_MDU_busy}, 32'd0);
    check("ovl hi", E_HI, 32'd3);
    check("ovl lo", E_LO, 32'd0);
    step();
    check("ovl after busy", {31'd0, E_MDU_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
